pe_mac_stream: RTL and testbench

//  Parametrised streaming processing element for the conv datapath: accepts one IFM/Weight pair
//  per valid/ready transfer, accumulates a run-time number of products (e.g. 27 for 3x3x3) and

---
 rtl/pe_mac_stream.sv | 177 +++++++++++++++++
 tb/tb_pe_mac_stream.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pe_mac_stream.sv
// pe_mac_stream: streaming multiply-accumulate processing element.
//   Takes one IFM/Weight pair per valid/ready transfer. It accumulates cfg_len
//   products (0 means 1) and then emits one OFM word per window. That word is
//   the sum shifted right by cfg_shift and saturated to OUT_W bits.
//   The datapath has two stages:
//     stage 1 registers the product.
//     stage 2 accumulates and produces OFM.
//   The whole pipe stalls while OFM is held for the consumer.
// Ports:
//   clk, reset_n      clock, async active-low reset
//   clear             synchronous flush of window, pipeline and out_valid
//   cfg_len/_signed/_shift  window config, latched on a window's first pair
//   in_valid/in_ready, IFM, Weight    input stream
//   OFM/out_valid/out_ready           output stream
//   busy              window in progress or pipeline occupied
module pe_mac_stream #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 32,
  parameter int OUT_W  = 16,
  parameter int LEN_W  = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              clear,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic              cfg_signed,
  input  logic [4:0]        cfg_shift,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] IFM,
  input  logic [DATA_W-1:0] Weight,
  output logic [OUT_W-1:0]  OFM,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy
);
  localparam int PW = 2 * DATA_W;

  logic [LEN_W-1:0] cnt_q, cnt_d, len_q, len_d;
  logic             sgn_q, sgn_d;
  logic [4:0]       shift_q, shift_d;
  logic             s1_vld_q, s1_vld_d, s1_last_q, s1_last_d, s1_sgn_q, s1_sgn_d;
  logic [PW-1:0]    prod_q, prod_d;
  logic [4:0]       s1_shift_q, s1_shift_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic             acc_open_q, acc_open_d;
  logic [OUT_W-1:0] ofm_q, ofm_d;
  logic             out_valid_q, out_valid_d;

  logic             adv, xfer, first, sgn_eff;
  logic [LEN_W-1:0] len_eff;
  logic [4:0]       shift_eff;
  logic [PW-1:0]    prod_u, prod_s;
  logic [ACC_W-1:0] ext, sum, shifted, fill;
  logic [OUT_W-1:0] sat;
  logic [ACC_W-OUT_W:0]   hi_s;
  logic [ACC_W-OUT_W-1:0] hi_u;

  always_comb begin
    adv   = ~(out_valid_q & ~out_ready);
    xfer  = in_valid & adv & ~clear;
    first = (cnt_q == '0);
    // The first pair of a window uses live config; later pairs use the latched copy.
    len_eff   = first ? ((cfg_len == '0) ? LEN_W'(1) : cfg_len) : len_q;
    sgn_eff   = first ? cfg_signed : sgn_q;
    shift_eff = first ? cfg_shift  : shift_q;

    // The low PW bits of a product of sign-extended operands equal the signed product.
    prod_u = {{DATA_W{1'b0}}, IFM} * {{DATA_W{1'b0}}, Weight};
    prod_s = {{DATA_W{IFM[DATA_W-1]}}, IFM} * {{DATA_W{Weight[DATA_W-1]}}, Weight};

    ext = s1_sgn_q ? {{(ACC_W-PW){prod_q[PW-1]}}, prod_q}
                   : {{(ACC_W-PW){1'b0}}, prod_q};
    sum = acc_q + ext;

    // Arithmetic shift is built as a logical shift plus the vacated top bits filled with the sign.
    fill    = ~({ACC_W{1'b1}} >> s1_shift_q);
    shifted = (sum >> s1_shift_q) | ((s1_sgn_q & sum[ACC_W-1]) ? fill : '0);

    hi_s = shifted[ACC_W-1:OUT_W-1];
    hi_u = shifted[ACC_W-1:OUT_W];
    if (s1_sgn_q) begin
      if ((&hi_s) | ~(|hi_s)) sat = shifted[OUT_W-1:0];
      else if (shifted[ACC_W-1]) sat = {1'b1, {(OUT_W-1){1'b0}}};
      else sat = {1'b0, {(OUT_W-1){1'b1}}};
    end else begin
      sat = (|hi_u) ? {OUT_W{1'b1}} : shifted[OUT_W-1:0];
    end

    // Stage 1 defaults.
    cnt_d      = cnt_q;
    len_d      = len_q;
    sgn_d      = sgn_q;
    shift_d    = shift_q;
    s1_vld_d   = s1_vld_q;
    s1_last_d  = s1_last_q;
    s1_sgn_d   = s1_sgn_q;
    s1_shift_d = s1_shift_q;
    prod_d     = prod_q;
    // Stage 2 defaults.
    acc_d       = acc_q;
    acc_open_d  = acc_open_q;
    ofm_d       = ofm_q;
    out_valid_d = out_valid_q;

    if (clear) begin
      cnt_d       = '0;
      s1_vld_d    = 1'b0;
      acc_d       = '0;
      acc_open_d  = 1'b0;
      out_valid_d = 1'b0;
    end else if (adv) begin
      s1_vld_d = xfer;
      if (xfer) begin
        prod_d     = sgn_eff ? prod_s : prod_u;
        s1_last_d  = (cnt_q == len_eff - LEN_W'(1));
        s1_sgn_d   = sgn_eff;
        s1_shift_d = shift_eff;
        cnt_d      = (cnt_q == len_eff - LEN_W'(1)) ? '0 : cnt_q + LEN_W'(1);
        if (first) begin
          len_d   = len_eff;
          sgn_d   = sgn_eff;
          shift_d = shift_eff;
        end
      end
      // adv means any held OFM is being taken now, so out_valid tracks only a new final.
      out_valid_d = s1_vld_q & s1_last_q;
      if (s1_vld_q) begin
        if (s1_last_q) begin
          acc_d      = '0;
          acc_open_d = 1'b0;
          ofm_d      = sat;
        end else begin
          acc_d      = sum;
          acc_open_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q       <= '0;
      len_q       <= '0;
      sgn_q       <= 1'b0;
      shift_q     <= '0;
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sgn_q    <= 1'b0;
      s1_shift_q  <= '0;
      prod_q      <= '0;
      acc_q       <= '0;
      acc_open_q  <= 1'b0;
      ofm_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      len_q       <= len_d;
      sgn_q       <= sgn_d;
      shift_q     <= shift_d;
      s1_vld_q    <= s1_vld_d;
      s1_last_q   <= s1_last_d;
      s1_sgn_q    <= s1_sgn_d;
      s1_shift_q  <= s1_shift_d;
      prod_q      <= prod_d;
      acc_q       <= acc_d;
      acc_open_q  <= acc_open_d;
      ofm_q       <= ofm_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = adv & ~clear;
  assign OFM       = ofm_q;
  assign out_valid = out_valid_q;
  assign busy      = (cnt_q != '0) | s1_vld_q | acc_open_q;
endmodule

// File: tb/tb_pe_mac_stream.sv
// Testbench for pe_mac_stream. The stimulus pushes expected OFM words into
// exp_q. A negedge monitor pops one entry for each OFM handshake and compares it.
// The directed windows push expected constants. The random windows push results
// from an integer reference model.
module tb_pe_mac_stream;
  logic        clk = 0, reset_n = 0, clear = 0;
  logic [7:0]  cfg_len = 1;
  logic        cfg_signed = 0;
  logic [4:0]  cfg_shift = 0;
  logic        in_valid = 0, in_ready;
  logic [7:0]  IFM = 0, Weight = 0;
  logic [15:0] OFM;
  logic        out_valid, out_ready = 1, busy;

  int checks = 0, failures = 0;
  logic [15:0] exp_q[$];
  bit   stalled = 0;
  logic [15:0] held;
  bit   use_model = 0, rand_rdy = 0;

  int m_cnt = 0, m_len = 1, m_shift = 0;
  bit m_sgn = 0;
  longint m_sum = 0;

  pe_mac_stream #(.DATA_W(8), .ACC_W(32), .OUT_W(16), .LEN_W(8)) dut (
    .clk(clk), .reset_n(reset_n), .clear(clear), .cfg_len(cfg_len),
    .cfg_signed(cfg_signed), .cfg_shift(cfg_shift), .in_valid(in_valid),
    .in_ready(in_ready), .IFM(IFM), .Weight(Weight), .OFM(OFM),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy));

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference model: plain integer sum of products, then shift and clamp.
  function automatic logic [15:0] ref_result(input longint s, input bit sg, input int sh);
    longint v;
    if (sg) begin
      v = longint'(int'(s[31:0])) >>> sh;
      if (v > 32767) v = 32767;
      if (v < -32768) v = -32768;
    end else begin
      v = (s & 64'hFFFF_FFFF) >> sh;
      if (v > 65535) v = 65535;
    end
    return v[15:0];
  endfunction

  function automatic void model_accept(input logic [7:0] a, input logic [7:0] b);
    if (m_cnt == 0) begin
      m_len = (cfg_len == 0) ? 1 : int'(cfg_len);
      m_sgn = cfg_signed; m_shift = int'(cfg_shift); m_sum = 0;
    end
    if (m_sgn) m_sum += longint'($signed(a)) * longint'($signed(b));
    else       m_sum += longint'(a) * longint'(b);
    m_cnt++;
    if (m_cnt == m_len) begin
      exp_q.push_back(ref_result(m_sum, m_sgn, m_shift));
      m_cnt = 0;
    end
  endfunction

  // Offer one pair and return at posedge+1 of its accept edge.
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int t = 0;
    IFM = a; Weight = b; in_valid = 1;
    @(negedge clk);
    while (!in_ready) begin
      t++;
      if (t > 500) begin
        checks++; failures++;
        $display("FAIL send_timeout in_ready=0 required=1");
        in_valid = 0;
        return;
      end
      @(negedge clk);
    end
    @(posedge clk); #1;
    in_valid = 0;
    if (use_model) model_accept(a, b);
  endtask

  task automatic drain(input string name);
    int t = 0;
    while ((exp_q.size() != 0 || busy) && t < 300) begin @(posedge clk); #1; t++; end
    chk({name, "_drain_pending"}, exp_q.size(), 0);
  endtask

  // Scoreboard monitor.
  always @(negedge clk) begin
    if (!reset_n) stalled = 0;
    else begin
      if (stalled && out_valid) chk("ofm_hold", OFM, held);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("unexpected_ofm", OFM, 17'h10000);
        else chk("ofm", OFM, exp_q.pop_front());
        stalled = 0;
      end else if (out_valid) begin
        stalled = 1; held = OFM;
      end else stalled = 0;
    end
  end

  always @(posedge clk) if (rand_rdy) begin #1; out_ready = ($urandom_range(0, 3) != 0); end

  initial begin
    // Reset state
    #3;
    chk("rst_ofm", OFM, 0); chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0); chk("rst_in_ready", in_ready, 1);
    @(negedge clk); reset_n = 1;
    @(posedge clk); #1;

    // 1: unsigned 27 x (1*2) = 54, checked for latency too
    cfg_len = 27; cfg_signed = 0; cfg_shift = 0;
    for (int i = 0; i < 27; i++) send(8'd1, 8'd2);
    exp_q.push_back(16'h0036);
    chk("t1_no_early_valid", out_valid, 0);
    @(posedge clk); #1;
    chk("t1_valid_latency", out_valid, 1); chk("t1_ofm", OFM, 16'h0036);
    @(posedge clk); #1;
    chk("t1_single_pulse", out_valid, 0);

    // 2: signed saturation and arithmetic shift
    cfg_len = 3; cfg_signed = 1; cfg_shift = 0;
    for (int i = 0; i < 3; i++) send(8'h80, 8'h7F);
    exp_q.push_back(16'h8000);
    cfg_shift = 2;
    for (int i = 0; i < 3; i++) send(8'h80, 8'h7F);
    exp_q.push_back(16'hD060);

    // 3: unsigned saturation, len=0 treated as 1
    cfg_signed = 0; cfg_shift = 0; cfg_len = 2;
    for (int i = 0; i < 2; i++) send(8'hFF, 8'hFF);
    exp_q.push_back(16'hFFFF);
    cfg_len = 0;
    send(8'd3, 8'd4);
    exp_q.push_back(16'h000C);
    drain("t3");

    // 4: backpressure on len=1 stream
    cfg_len = 1;
    fork
      for (int i = 1; i <= 4; i++) begin send(8'(i), 8'd1); exp_q.push_back(16'(i)); end
      begin
        int t = 0;
        do begin @(posedge clk); #1; t++; end while (!out_valid && t < 50);
        out_ready = 0;
        for (int k = 0; k < 3; k++) begin
          @(posedge clk); #1;
          chk("t4_in_ready_low", in_ready, 0);
          chk("t4_ofm_held", OFM, 1);
          chk("t4_valid_held", out_valid, 1);
        end
        out_ready = 1;
      end
    join
    drain("t4");

    // 5: clear mid-window, then mid-window cfg_len change ignored
    cfg_len = 27;
    for (int i = 0; i < 10; i++) send(8'd1, 8'd1);
    chk("t5_busy_partial", busy, 1);
    clear = 1; in_valid = 1; IFM = 8'd9; Weight = 8'd9;
    #1 chk("t5_in_ready_clear", in_ready, 0);
    @(posedge clk); #1;
    clear = 0; in_valid = 0;
    chk("t5_busy_after_clear", busy, 0);
    send(8'd1, 8'd1);
    cfg_len = 5;
    for (int i = 0; i < 26; i++) send(8'd1, 8'd1);
    exp_q.push_back(16'h001B);
    drain("t5");

    // 6: async reset with a held result and a partial window
    cfg_len = 2; out_ready = 0;
    send(8'd5, 8'd5); send(8'd5, 8'd5); send(8'd7, 8'd7);
    chk("t6_pre_valid", out_valid, 1); chk("t6_pre_busy", busy, 1);
    #3 reset_n = 0;
    #1;
    chk("t6_rst_ofm", OFM, 0); chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_busy", busy, 0);
    exp_q.delete();
    @(negedge clk); reset_n = 1; out_ready = 1;
    @(posedge clk); #1;
    cfg_len = 3;
    for (int i = 0; i < 3; i++) send(8'd2, 8'd2);
    exp_q.push_back(16'h000C);
    drain("t6");

    // Random windows against the reference model; config wiggles mid-window.
    use_model = 1; m_cnt = 0; rand_rdy = 1;
    for (int w = 0; w < 60; w++) begin
      cfg_len = 8'($urandom_range(0, 6));
      cfg_signed = 1'($urandom_range(0, 1));
      cfg_shift = 5'($urandom_range(0, 12));
      do begin
        send(8'($urandom), 8'($urandom));
        cfg_len = 8'($urandom_range(0, 6));
        cfg_signed = 1'($urandom_range(0, 1));
        cfg_shift = 5'($urandom_range(0, 12));
      end while (m_cnt != 0);
    end
    rand_rdy = 0; #1 out_ready = 1;
    drain("rand");
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
